neuron_window_ctrl: RTL and testbench
=====================================

# neuron_window_ctrl

Sequencer that sits in front of `neuron_unit`. It gathers a serial stream of 49 fp32 pixels into a 7×7 window and presents the window on the seven 224-bit line buses with a one-cycle `de` strobe. After a fixed latency it captures the four fp32 symbol outputs, selects the winning class by argmax, and hands the result downstream through a valid/ready handshake. It runs one window at a time and is the sole driver of `neuron_unit`'s inputs.

## Interface

Parameters:
- `LATENCY`, default 4: cycles from the `de_out` cycle to the cycle in which the symbol inputs are valid. Legal range is 1–255.

Ports (all synchronous to `clk`):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pix_valid`  in  1  pixel stream valid.
- `pix_ready`  out  1  pixel stream ready.
- `pix_sof`  in  1  marks the pixel as window element (row 0, col 0).
- `pix_data`  in  32  fp32 pixel.
- `de_out`  out  1  window strobe; drives `neuron_unit.de_in`.
- `line_0_out` … `line_6_out`  out  224 each  window rows; drive `line_0_in` … `line_6_in`.
- `sym_0_in` … `sym_3_in`  in  32 each  fp32 symbols from `neuron_unit`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result ready.
- `res_class`  out  2  index of the winning symbol.
- `res_score`  out  32  fp32 value of the winning symbol.
- `frame_cnt`  out  16  count of completed result handshakes; wraps at 0xFFFF→0.

## Operation

- FSM states: LOAD, FIRE, WAIT, OUT.
- LOAD:
  - `pix_ready`=1.
  - Each accepted pixel (`pix_valid & pix_ready`) with index k (0..48) is written to row r=k/7, col c=k%7.
  - Packing: `line_r_out` = {p[r][0], …, p[r][6]}, so p[r][0] occupies [223:192] and p[r][6] occupies [31:0].
  - Accepting k=48 moves the FSM to FIRE.
- `pix_sof` resync: an accepted pixel with `pix_sof`=1 is always stored as k=0, and the count restarts from it. `pix_sof` on k=0 is a no-op restart. Pixels accepted without `pix_sof` while k=0 are accepted normally; `pix_sof` is not required.
- FIRE (one cycle): `de_out`=1, then WAIT.
- WAIT: counts `LATENCY` cycles.
  - At the rising edge ending cycle F+`LATENCY` (F = the FIRE cycle), sample `sym_0_in`..`sym_3_in`, compute the argmax, register `res_class`/`res_score`, and go to OUT.
- Argmax ordering:
  - Map each symbol s to a 32-bit key: if s[31]=1 the key is ~s, else the key is s ^ 0x80000000. Compare keys unsigned.
  - Ties resolve to the lowest index. NaNs get no special handling; they are ordered by key.
- OUT: `res_valid`=1 until `res_valid & res_ready`. On that edge `frame_cnt` increments, k resets to 0, and the FSM returns to LOAD.
- `pix_ready`=0 in FIRE, WAIT and OUT. Pixel inputs are ignored in those states; there is no overlap of loading with evaluation.
- Line registers hold from FIRE through OUT. They are overwritten only by new pixels in LOAD and are never cleared between windows.

## Timing

- Reset (synchronous):
  - State becomes LOAD, k=0, and WAIT counter=0.
  - All line outputs, `res_class`, `res_score` and `frame_cnt` become 0; `de_out` and `res_valid` become 0.
  - `pix_ready`=0 while `reset` is high and 1 in the first cycle after it drops.
- Reset mid-operation (any state) aborts the window. No `de_out` or `res_valid` follows.
- Cycle timeline, with A = the cycle of the 49th accept:
  - A+1: FIRE (`de_out`=1).
  - A+1+`LATENCY`: symbol sample edge.
  - A+2+`LATENCY`: first cycle with `res_valid`=1.
- `res_valid`, `res_class` and `res_score` are stable while `res_valid`=1 and `res_ready`=0.
- After the result handshake, `pix_ready`=1 in the next cycle.
- Minimum period per window is 49 + 1 + `LATENCY` + 1 cycles.
- Gaps in `pix_valid` stall the count and do not reset it.

## Test plan

- **Reset:** hold `reset` 3 cycles with random inputs → all outputs 0 and `pix_ready`=0; after release, `pix_ready`=1 and `frame_cnt`=0.
- **Packing:** send pixels with raw bits = k (0..48), no gaps, `LATENCY`=4.
  - Line contents: `line_0_out`[223:192]=0x0, `line_0_out`[31:0]=0x6, `line_6_out`[223:192]=0x2A, `line_6_out`[31:0]=0x30.
  - `de_out`=1 for exactly cycle A+1, and `res_valid` rises at A+6.
- **Argmax:**
  - Symbols {0xBF800000, 0x40000000, 0x40000000, 0x3F800000} → class 1, score 0x40000000.
  - Symbols {-3.0, -1.0, -2.0, -4.0} → class 1, score 0xBF800000.
  - Symbols {+0.0, -0.0, 0x00000000, 0x80000000} → class 0.
- **Backpressure:** hold `res_ready`=0 for 10 cycles → `res_valid` and result are held, `pix_ready`=0, and asserted `pix_valid` is ignored; raise `res_ready` → `frame_cnt`=1 and `pix_ready`=1 next cycle.
- **Resync:** send 20 pixels, then a pixel 0x11111111 with `pix_sof`=1, then 48 more → `line_0_out`[223:192]=0x11111111, and FIRE occurs only after the 49th post-sof pixel.
- **Abort:** assert `reset` during WAIT → LOAD next cycle, no `res_valid`, `frame_cnt` unchanged at 0, all lines 0.

Source files
------------

// File: rtl/neuron_window_ctrl.sv
// Gathers 49 serial fp32 pixels into a 7x7 window, strobes it into neuron_unit, then argmaxes the four symbols.
// Window period 49+1+LATENCY+1 cycles; pix_ready stays low from FIRE until the result handshake completes.
module neuron_window_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic         pix_sof,
  input  logic [31:0]  pix_data,
  output logic         de_out,
  output logic [223:0] line_0_out,
  output logic [223:0] line_1_out,
  output logic [223:0] line_2_out,
  output logic [223:0] line_3_out,
  output logic [223:0] line_4_out,
  output logic [223:0] line_5_out,
  output logic [223:0] line_6_out,
  input  logic [31:0]  sym_0_in,
  input  logic [31:0]  sym_1_in,
  input  logic [31:0]  sym_2_in,
  input  logic [31:0]  sym_3_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [1:0]   res_class,
  output logic [31:0]  res_score,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT, S_OUT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [2:0]    row_q, col_q, wr_row, wr_col;
  logic [7:0]    wr_lsb, wait_q;
  logic          accept, last_pix, wait_done, handshake;
  logic [223:0]  line_q [7];
  logic [31:0]   sym [4];
  logic [1:0]    best_idx;
  logic [31:0]   best_key;

  // Maps fp32 onto an unsigned key whose order matches the float order (-0 sorts below +0).
  function automatic logic [31:0] order_key(input logic [31:0] s);
    return s[31] ? ~s : (s ^ 32'h8000_0000);
  endfunction

  assign sym[0] = sym_0_in;
  assign sym[1] = sym_1_in;
  assign sym[2] = sym_2_in;
  assign sym[3] = sym_3_in;

  // A sof pixel always lands at (0,0), whatever the running count says.
  assign wr_row    = pix_sof ? 3'd0 : row_q;
  assign wr_col    = pix_sof ? 3'd0 : col_q;
  assign wr_lsb    = {3'd6 - wr_col, 5'd0};
  assign accept    = pix_valid & pix_ready;
  assign last_pix  = accept && (wr_row == 3'd6) && (wr_col == 3'd6);
  assign wait_done = (wait_q == WAIT_LAST);
  assign handshake = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (last_pix)  state_d = S_FIRE;
      S_FIRE:                state_d = S_WAIT;
      S_WAIT: if (wait_done) state_d = S_OUT;
      S_OUT:  if (res_ready) state_d = S_LOAD;
      default:               state_d = S_LOAD;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == S_LOAD) && !reset;
    de_out    = (state_q == S_FIRE) && !reset;
    res_valid = (state_q == S_OUT)  && !reset;
  end

  // Lowest index wins ties because only a strictly larger key replaces the incumbent.
  always_comb begin
    best_idx = 2'd0;
    best_key = order_key(sym[0]);
    for (int i = 1; i < 4; i++) begin
      if (order_key(sym[i]) > best_key) begin
        best_idx = 2'(i);
        best_key = order_key(sym[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      wait_q    <= 8'd0;
      res_class <= 2'd0;
      res_score <= 32'd0;
      frame_cnt <= 16'd0;
      for (int r = 0; r < 7; r++) line_q[r] <= 224'd0;
    end else begin
      if (accept) begin
        for (int r = 0; r < 7; r++) begin
          if (wr_row == 3'(r)) line_q[r][wr_lsb +: 32] <= pix_data;
        end
        // The count is parked at zero once the window is complete, ready for the next one.
        if (last_pix) begin
          row_q <= 3'd0;
          col_q <= 3'd0;
        end else if (wr_col == 3'd6) begin
          row_q <= wr_row + 3'd1;
          col_q <= 3'd0;
        end else begin
          row_q <= wr_row;
          col_q <= wr_col + 3'd1;
        end
      end
      wait_q <= (state_q == S_WAIT && !wait_done) ? wait_q + 8'd1 : 8'd0;
      if (state_q == S_WAIT && wait_done) begin
        res_class <= best_idx;
        res_score <= sym[best_idx];
      end
      if (handshake) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign line_0_out = line_q[0];
  assign line_1_out = line_q[1];
  assign line_2_out = line_q[2];
  assign line_3_out = line_q[3];
  assign line_4_out = line_q[4];
  assign line_5_out = line_q[5];
  assign line_6_out = line_q[6];

endmodule

// File: tb/tb_neuron_window_ctrl.sv
// Scoreboard bench for neuron_window_ctrl: the driver queues expected results, a monitor checks them at handshakes.
module tb_neuron_window_ctrl;

  localparam int LAT = 4;

  typedef logic [48:0][31:0] win_t;
  typedef struct packed {
    logic [1:0]         cls;
    logic [31:0]        score;
    logic [6:0][223:0]  lines;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic         pix_sof = 1'b0;
  logic [31:0]  pix_data = 32'd0;
  logic         de_out;
  logic [223:0] line_0_out, line_1_out, line_2_out, line_3_out, line_4_out, line_5_out, line_6_out;
  logic [31:0]  sym_0_in = 32'd0, sym_1_in = 32'd0, sym_2_in = 32'd0, sym_3_in = 32'd0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [1:0]   res_class;
  logic [31:0]  res_score;
  logic [15:0]  frame_cnt;

  logic [6:0][223:0] dut_lines;
  assign dut_lines = {line_6_out, line_5_out, line_4_out, line_3_out, line_2_out, line_1_out, line_0_out};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fire_cyc = -1000;
  int hs_count = 0;
  int hs_base = 0;
  int mode = 0;
  bit mon_en = 1'b0;
  bit prev_rv = 1'b0;
  exp_t         exp_q[$];
  logic [127:0] sym_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_window_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
    .de_out(de_out),
    .line_0_out(line_0_out), .line_1_out(line_1_out), .line_2_out(line_2_out), .line_3_out(line_3_out),
    .line_4_out(line_4_out), .line_5_out(line_5_out), .line_6_out(line_6_out),
    .sym_0_in(sym_0_in), .sym_1_in(sym_1_in), .sym_2_in(sym_2_in), .sym_3_in(sym_3_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fkey(input logic [31:0] s);
    return s[31] ? ~s : (s ^ 32'h8000_0000);
  endfunction

  // Reference: lay the 49 pixels out row-major, pick the largest float (first one on ties).
  function automatic exp_t model(input win_t px, input logic [127:0] sy);
    exp_t m;
    int best;
    m = '0;
    for (int k = 0; k < 49; k++) m.lines[k / 7][(6 - k % 7) * 32 +: 32] = px[k];
    best = 0;
    for (int i = 1; i < 4; i++)
      if (fkey(sy[32 * i +: 32]) > fkey(sy[32 * best +: 32])) best = i;
    m.cls   = 2'(best);
    m.score = sy[32 * best +: 32];
    return m;
  endfunction

  // Plays neuron_unit: symbols are only meaningful in the single sample cycle.
  always @(negedge clk) begin
    if (cyc == fire_cyc + LAT && sym_q.size() > 0) begin
      {sym_3_in, sym_2_in, sym_1_in, sym_0_in} = sym_q.pop_front();
    end else begin
      sym_0_in = $urandom; sym_1_in = $urandom; sym_2_in = $urandom; sym_3_in = $urandom;
    end
  end

  // Monitor: drives res_ready, checks strobe timing and every presented result.
  always @(negedge clk) begin
    if (mode == 1)      res_ready = 1'b0;
    else if (mode == 2) res_ready = 1'b1;
    else                res_ready = ($urandom_range(0, 3) != 0);
    if (mon_en && !reset) begin
      chk("de_out", 224'(de_out), 224'(cyc == fire_cyc));
      if (res_valid) begin
        if (!prev_rv) chk("res_valid_rise_cycle", 224'(cyc), 224'(fire_cyc + LAT + 1));
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got res_valid=1 expected no result pending");
        end else begin
          chk("res_class", 224'(res_class), 224'(exp_q[0].cls));
          chk("res_score", 224'(res_score), 224'(exp_q[0].score));
          if (res_ready) begin
            for (int r = 0; r < 7; r++) chk($sformatf("line_%0d", r), dut_lines[r], exp_q[0].lines[r]);
            chk("frame_cnt_at_hs", 224'(frame_cnt), 224'(16'(hs_count - hs_base)));
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
      prev_rv = res_valid;
    end
  end

  task automatic run_window(input win_t px, input logic [127:0] sy, input int pre,
                            input bit gaps, input bit bp, input bit abort);
    logic [31:0] dat[$];
    bit          sofs[$];
    int          i, guard, start, vcnt;
    for (int p = 0; p < pre; p++) begin dat.push_back($urandom); sofs.push_back(1'b0); end
    dat.push_back(px[0]);
    sofs.push_back(pre > 0 ? 1'b1 : 1'($urandom_range(0, 1)));
    for (int k = 1; k < 49; k++) begin dat.push_back(px[k]); sofs.push_back(1'b0); end
    if (!abort) begin
      sym_q.push_back(sy);
      exp_q.push_back(model(px, sy));
    end
    i = 0; guard = 0;
    while (i < dat.size() && guard < 1000) begin
      @(negedge clk); #1; guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0; pix_sof = 1'($urandom_range(0, 1)); pix_data = $urandom;
      end else begin
        chk("pix_ready_load", 224'(pix_ready), 224'(1));
        pix_valid = 1'b1; pix_data = dat[i]; pix_sof = sofs[i];
        if (i == dat.size() - 1) fire_cyc = cyc + 1;
        i++;
      end
    end
    if (abort) begin
      repeat (2) begin
        @(negedge clk); #1;
        chk("pix_ready_busy", 224'(pix_ready), 224'(0));
        pix_valid = 1'b1; pix_data = $urandom;
      end
      reset = 1'b1; pix_valid = 1'b0; fire_cyc = -1000;
      @(negedge clk); #1;
      reset = 1'b0;
      chk("abort_res_valid", 224'(res_valid), 224'(0));
      chk("abort_de_out", 224'(de_out), 224'(0));
      @(negedge clk); #1;
      hs_base = hs_count;
      chk("abort_pix_ready", 224'(pix_ready), 224'(1));
      chk("abort_frame_cnt", 224'(frame_cnt), 224'(0));
      chk("abort_res_valid2", 224'(res_valid), 224'(0));
      for (int r = 0; r < 7; r++) chk($sformatf("abort_line_%0d", r), dut_lines[r], 224'(0));
      return;
    end
    start = hs_count; vcnt = 0; guard = 0;
    if (bp) mode = 1;
    while (hs_count == start && guard < 300) begin
      @(negedge clk); #1; guard++;
      if (hs_count != start) break;
      chk("pix_ready_busy", 224'(pix_ready), 224'(0));
      pix_valid = 1'b1; pix_data = $urandom; pix_sof = 1'($urandom_range(0, 1));
      if (bp && res_valid) begin
        vcnt++;
        if (vcnt == 10) mode = 2;
      end
    end
    pix_valid = 1'b0;
    if (hs_count == start) begin
      checks++; errors++;
      $display("FAIL result_timeout: got no handshake expected one within 300 cycles");
    end
    @(negedge clk); #1;
    mode = 0;
    chk("pix_ready_after_hs", 224'(pix_ready), 224'(1));
    chk("frame_cnt_after_hs", 224'(frame_cnt), 224'(16'(hs_count - hs_base)));
  endtask

  function automatic win_t rand_win();
    win_t w;
    for (int k = 0; k < 49; k++) w[k] = $urandom;
    return w;
  endfunction

  function automatic logic [127:0] rand_syms();
    logic [127:0] s;
    for (int i = 0; i < 4; i++) s[32 * i +: 32] = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      int a, b;
      a = $urandom_range(0, 2);
      b = $urandom_range(a + 1, 3);
      s[32 * b +: 32] = s[32 * a +: 32];
    end
    return s;
  endfunction

  initial begin
    win_t px;
    repeat (200000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got no completion expected finish before cycle limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    win_t px;
    repeat (3) begin
      @(negedge clk); #1;
      pix_valid = 1'($urandom_range(0, 1)); pix_sof = 1'($urandom_range(0, 1)); pix_data = $urandom;
    end
    chk("rst_pix_ready", 224'(pix_ready), 224'(0));
    chk("rst_de_out", 224'(de_out), 224'(0));
    chk("rst_res_valid", 224'(res_valid), 224'(0));
    chk("rst_res_class", 224'(res_class), 224'(0));
    chk("rst_res_score", 224'(res_score), 224'(0));
    chk("rst_frame_cnt", 224'(frame_cnt), 224'(0));
    for (int r = 0; r < 7; r++) chk($sformatf("rst_line_%0d", r), dut_lines[r], 224'(0));
    pix_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_pix_ready", 224'(pix_ready), 224'(1));
    chk("post_rst_frame_cnt", 224'(frame_cnt), 224'(0));
    mon_en = 1'b1;

    // Packing pattern (raw bits = index) doubles as the backpressure window.
    for (int k = 0; k < 49; k++) px[k] = 32'(k);
    run_window(px, rand_syms(), 0, 1'b0, 1'b1, 1'b0);
    chk("bp_frame_cnt", 224'(frame_cnt), 224'(1));

    run_window(rand_win(), {32'h3F800000, 32'h40000000, 32'h40000000, 32'hBF800000}, 0, 1'b1, 1'b0, 1'b0);
    run_window(rand_win(), {32'hC0800000, 32'hC0000000, 32'hBF800000, 32'hC0400000}, 0, 1'b1, 1'b0, 1'b0);
    run_window(rand_win(), {32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000}, 0, 1'b1, 1'b0, 1'b0);

    px = rand_win();
    px[0] = 32'h11111111;
    run_window(px, rand_syms(), 20, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 8; n++)
      run_window(rand_win(), rand_syms(), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 48) : 0,
                 1'b1, 1'b0, 1'b0);

    run_window(rand_win(), rand_syms(), 0, 1'b1, 1'b0, 1'b1);
    run_window(rand_win(), rand_syms(), 0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
